calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Keypad-to-ALU sequencer for the calculator. It sits downstream of the keypad scanner and consumes its one-cycle key event with the row/column code. It decodes keys, accumulates two decimal operands and an operator, and issues one request at a time to the arithmetic unit over a req/done handshake. It then holds the result, or an error flag, for the display.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits
- DIGITS, 4, max decimal digits per operand; 10^DIGITS-1 must fit in WIDTH (not checked)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- key_ev  in  1  one-cycle key event pulse from scanner
- key_row  in  4  row code, one bit low; bit3 low = row 0 … bit0 low = row 3
- key_col  in  4  column code, same encoding; bit3 low = col 0
- alu_req  out  1  request to ALU, held until done
- alu_op  out  2  00 add, 01 sub, 10 mul, 11 div
- alu_a  out  WIDTH  operand A
- alu_b  out  WIDTH  operand B
- alu_done  in  1  one-cycle completion pulse
- alu_result  in  WIDTH  result, valid with alu_done
- alu_err  in  1  error (overflow/div-by-zero), valid with alu_done
- disp_val  out  WIDTH  value to display
- disp_err  out  1  error indicator
- busy  out  1  high while in EXEC

## Operation
- Key map (row: col0 col1 col2 col3): r0: 1 2 3 +; r1: 4 5 6 −; r2: 7 8 9 *; r3: C 0 = /.
- Event valid only if key_row and key_col each have exactly one zero bit. Otherwise the event is ignored with no state change.
- Registers: acc_a, acc_b (WIDTH), op (2b), dcnt (digits entered in current operand), state.
- States: ENTER_A (reset state), ENTER_B, EXEC, SHOW, ERROR.
- ENTER_A:
  - digit d: if dcnt < DIGITS then acc_a = acc_a*10+d (mod 2^WIDTH), dcnt++; else ignored.
  - operator: op latched, acc_b = 0, dcnt = 0, go to ENTER_B.
  - '=': ignored.
- ENTER_B:
  - digit: accumulates into acc_b, same rule.
  - operator: if dcnt == 0, replaces op; else ignored.
  - '=': go to EXEC; acc_b used as-is (0 if no digits).
- EXEC: alu_req = 1 with alu_a = acc_a, alu_b = acc_b, alu_op = op, held stable. All key events, including C, are ignored.
  - alu_done with alu_err = 0: acc_a = alu_result, go to SHOW.
  - alu_done with alu_err = 1: disp_err = 1, go to ERROR.
- SHOW:
  - digit d: acc_a = d, dcnt = 1, go to ENTER_A.
  - operator: chain; acc_a kept, op latched, acc_b = 0, dcnt = 0, go to ENTER_B.
  - '=': ignored.
- ERROR: only C is accepted; all other keys are ignored.
- C (any state except EXEC): acc_a = acc_b = 0, op = 00, dcnt = 0, disp_err = 0, go to ENTER_A.
- disp_val:
  - acc_a in ENTER_A, EXEC and SHOW.
  - acc_b in ENTER_B once dcnt > 0; acc_a while dcnt == 0.
  - Holds its last value in ERROR.
- busy = (state == EXEC).
- alu_done outside EXEC is ignored.

## Timing
- Reset (asynchronous, while low): state ENTER_A, all registers 0. Outputs alu_req = 0, alu_op = 00, alu_a = alu_b = 0, disp_val = 0, disp_err = 0, busy = 0.
- key_ev, key_row and key_col are sampled on the same rising edge. Resulting state and disp_val are visible the next cycle (1-cycle latency).
- alu_req and busy rise the cycle after the '=' event is sampled.
- alu_done sampled high at edge N: alu_req and busy are low, and disp_val or disp_err are updated, from cycle N+1.
- A key event coincident with alu_done is ignored.
- alu_req never re-asserts before at least one cycle low.
- Reset asserted mid-EXEC: alu_req drops immediately (asynchronous). A late alu_done after reset release is ignored.
- No back-to-back key events are required, but each pulse must be handled independently (no event loss at 1 event per cycle).

## Test plan
- Reset: hold reset low 3 cycles, then release → all outputs 0, busy 0; key '5' then gives disp_val = 5.
- Keys 1,2,+,3,= → alu_req = 1, alu_a = 12, alu_b = 3, alu_op = 00. ALU returns done with result 15 three cycles later → next cycle alu_req = 0, disp_val = 15, busy = 0.
- Digit limit and chain:
  - keys 1,2,3,4,5 → disp_val = 1234.
  - then *,2,= → alu_a = 1234, alu_b = 2, alu_op = 10.
  - after result 2468: −,8,= → alu_a = 2468, alu_b = 8, alu_op = 01.
- Operator replace: keys 9,+,* → alu_op = 10 on '='. Keys 9,+,4,* → op stays 00.
- Error: keys 8,/,0,=, ALU done with alu_err = 1 → disp_err = 1. Then keys 7 and '=' → no change. Then C → disp_err = 0, disp_val = 0.
- Robustness:
  - event with key_row = 4'b0011 → ignored.
  - key '4' during EXEC → ignored, alu_a unchanged.
  - reset low during EXEC → alu_req = 0 same cycle; later alu_done pulse → no effect.

Source files
------------

// File: rtl/calc_sequencer.sv
// calc_sequencer: decodes keypad events, accumulates two decimal operands and
// an operator, issues one request at a time to the ALU over a req/done
// handshake, and holds the result or an error flag for the display.
module calc_sequencer #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_ev,
    input  logic [3:0]       key_row,
    input  logic [3:0]       key_col,
    output logic             alu_req,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic             alu_done,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_err,
    output logic [WIDTH-1:0] disp_val,
    output logic             disp_err,
    output logic             busy
);

    localparam int DW = $clog2(DIGITS + 1);

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        EXEC,
        SHOW,
        ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_a_q, acc_a_d;
    logic [WIDTH-1:0] acc_b_q, acc_b_d;
    logic [1:0]       op_q, op_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic             disp_err_q, disp_err_d;
    logic [WIDTH-1:0] disp_val_q, disp_val_d;

    // Decoded key event
    logic       row_ok, col_ok;
    logic [1:0] row_i, col_i;
    logic       k_digit, k_op, k_eq, k_clr;
    logic [3:0] k_val;
    logic [1:0] k_opc;

    // acc*10 + d, wrapping at WIDTH bits
    function automatic logic [WIDTH-1:0] mac10(input logic [WIDTH-1:0] acc,
                                               input logic [3:0] d);
        mac10 = acc * WIDTH'(10) + {{(WIDTH-4){1'b0}}, d};
    endfunction

    // Row/column one-cold decode and key classification; malformed codes drop the event
    always_comb begin
        row_ok  = 1'b1;
        col_ok  = 1'b1;
        row_i   = 2'd0;
        col_i   = 2'd0;
        k_digit = 1'b0;
        k_op    = 1'b0;
        k_eq    = 1'b0;
        k_clr   = 1'b0;
        k_val   = 4'd0;
        k_opc   = 2'd0;
        case (key_row)
            4'b0111: row_i = 2'd0;
            4'b1011: row_i = 2'd1;
            4'b1101: row_i = 2'd2;
            4'b1110: row_i = 2'd3;
            default: row_ok = 1'b0;
        endcase
        case (key_col)
            4'b0111: col_i = 2'd0;
            4'b1011: col_i = 2'd1;
            4'b1101: col_i = 2'd2;
            4'b1110: col_i = 2'd3;
            default: col_ok = 1'b0;
        endcase
        if (key_ev && row_ok && col_ok) begin
            if (col_i == 2'd3) begin
                // Column 3 holds + - * / in row order, matching the op encoding
                k_op  = 1'b1;
                k_opc = row_i;
            end else if (row_i == 2'd3) begin
                case (col_i)
                    2'd0:    k_clr = 1'b1;
                    2'd1:    k_digit = 1'b1;
                    default: k_eq = 1'b1;
                endcase
            end else begin
                k_digit = 1'b1;
                k_val   = {2'b00, row_i} * 4'd3 + {2'b00, col_i} + 4'd1;
            end
        end
    end

    // Next-state and register updates for the entry/exec/show/error flow
    always_comb begin
        state_d    = state_q;
        acc_a_d    = acc_a_q;
        acc_b_d    = acc_b_q;
        op_d       = op_q;
        dcnt_d     = dcnt_q;
        disp_err_d = disp_err_q;
        if (k_clr && state_q != EXEC) begin
            state_d    = ENTER_A;
            acc_a_d    = '0;
            acc_b_d    = '0;
            op_d       = 2'b00;
            dcnt_d     = '0;
            disp_err_d = 1'b0;
        end else begin
            case (state_q)
                ENTER_A: begin
                    if (k_digit && dcnt_q < DW'(DIGITS)) begin
                        acc_a_d = mac10(acc_a_q, k_val);
                        dcnt_d  = dcnt_q + 1'b1;
                    end else if (k_op) begin
                        op_d    = k_opc;
                        acc_b_d = '0;
                        dcnt_d  = '0;
                        state_d = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (k_digit && dcnt_q < DW'(DIGITS)) begin
                        acc_b_d = mac10(acc_b_q, k_val);
                        dcnt_d  = dcnt_q + 1'b1;
                    end else if (k_op && dcnt_q == '0) begin
                        op_d = k_opc;
                    end else if (k_eq) begin
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    // Keys are ignored here; only the ALU completion moves us on
                    if (alu_done) begin
                        if (alu_err) begin
                            disp_err_d = 1'b1;
                            state_d    = ERROR;
                        end else begin
                            acc_a_d = alu_result;
                            state_d = SHOW;
                        end
                    end
                end
                SHOW: begin
                    if (k_digit) begin
                        acc_a_d = {{(WIDTH-4){1'b0}}, k_val};
                        dcnt_d  = DW'(1);
                        state_d = ENTER_A;
                    end else if (k_op) begin
                        op_d    = k_opc;
                        acc_b_d = '0;
                        dcnt_d  = '0;
                        state_d = ENTER_B;
                    end
                end
                default: ;  // ERROR: only C, handled above
            endcase
        end
    end

    // Display value follows the operand being edited; frozen while in ERROR
    always_comb begin
        case (state_d)
            ERROR:   disp_val_d = disp_val_q;
            ENTER_B: disp_val_d = (dcnt_d != '0) ? acc_b_d : acc_a_d;
            default: disp_val_d = acc_a_d;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ENTER_A;
            acc_a_q    <= '0;
            acc_b_q    <= '0;
            op_q       <= 2'b00;
            dcnt_q     <= '0;
            disp_err_q <= 1'b0;
            disp_val_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_a_q    <= acc_a_d;
            acc_b_q    <= acc_b_d;
            op_q       <= op_d;
            dcnt_q     <= dcnt_d;
            disp_err_q <= disp_err_d;
            disp_val_q <= disp_val_d;
        end
    end

    // Request is decoded straight from the state flop so reset drops it at once
    assign alu_req  = (state_q == EXEC);
    assign busy     = (state_q == EXEC);
    assign alu_op   = op_q;
    assign alu_a    = acc_a_q;
    assign alu_b    = acc_b_q;
    assign disp_val = disp_val_q;
    assign disp_err = disp_err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed testbench for calc_sequencer with immediate-assertion checks.
module tb_calc_sequencer;

    logic        clk;
    logic        reset;
    logic        key_ev;
    logic [3:0]  key_row;
    logic [3:0]  key_col;
    logic        alu_req;
    logic [1:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        alu_err;
    logic [15:0] disp_val;
    logic        disp_err;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    calc_sequencer #(.WIDTH(16), .DIGITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_ev     (key_ev),
        .key_row    (key_row),
        .key_col    (key_col),
        .alu_req    (alu_req),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_err    (alu_err),
        .disp_val   (disp_val),
        .disp_err   (disp_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_key(input byte ch);
        logic [3:0] one;
        int r, c;
        one = 4'b1000;
        r = 0;
        c = 0;
        case (ch)
            "1": begin r = 0; c = 0; end
            "2": begin r = 0; c = 1; end
            "3": begin r = 0; c = 2; end
            "+": begin r = 0; c = 3; end
            "4": begin r = 1; c = 0; end
            "5": begin r = 1; c = 1; end
            "6": begin r = 1; c = 2; end
            "-": begin r = 1; c = 3; end
            "7": begin r = 2; c = 0; end
            "8": begin r = 2; c = 1; end
            "9": begin r = 2; c = 2; end
            "*": begin r = 2; c = 3; end
            "C": begin r = 3; c = 0; end
            "0": begin r = 3; c = 1; end
            "=": begin r = 3; c = 2; end
            default: begin r = 3; c = 3; end  // "/"
        endcase
        key_ev  = 1'b1;
        key_row = ~(one >> r);
        key_col = ~(one >> c);
    endtask

    // One key pulse; returns on the negedge after it was sampled
    task automatic press(input byte ch);
        @(negedge clk);
        set_key(ch);
        @(negedge clk);
        key_ev  = 1'b0;
        key_row = 4'hF;
        key_col = 4'hF;
    endtask

    task automatic press_str(input string s);
        for (int i = 0; i < s.len(); i++) press(s[i]);
    endtask

    task automatic alu_reply(input logic [15:0] res, input logic err);
        @(negedge clk);
        alu_done   = 1'b1;
        alu_result = res;
        alu_err    = err;
        @(negedge clk);
        alu_done   = 1'b0;
        alu_result = 16'd0;
        alu_err    = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        key_ev     = 1'b0;
        key_row    = 4'hF;
        key_col    = 4'hF;
        alu_done   = 1'b0;
        alu_result = 16'd0;
        alu_err    = 1'b0;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_req", alu_req, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_disp", disp_val, 0);
        chk("rst_err", disp_err, 0);
        chk("rst_a", alu_a, 0);
        chk("rst_b", alu_b, 0);
        chk("rst_op", alu_op, 0);
        press("5");
        chk("key5", disp_val, 5);

        // 12 + 3
        press("C");
        chk("clr_disp", disp_val, 0);
        press_str("12+");
        chk("after_plus_disp", disp_val, 12);
        press("3");
        chk("b_disp", disp_val, 3);
        press("=");
        chk("add_req", alu_req, 1);
        chk("add_busy", busy, 1);
        chk("add_a", alu_a, 12);
        chk("add_b", alu_b, 3);
        chk("add_op", alu_op, 0);
        repeat (2) @(negedge clk);
        chk("add_req_held", alu_req, 1);
        alu_reply(16'd15, 1'b0);
        chk("add_req_drop", alu_req, 0);
        chk("add_busy_drop", busy, 0);
        chk("add_disp", disp_val, 15);

        // Digit limit from SHOW, then chained operations
        press_str("12345");
        chk("limit_disp", disp_val, 1234);
        press_str("*2=");
        chk("mul_a", alu_a, 1234);
        chk("mul_b", alu_b, 2);
        chk("mul_op", alu_op, 2);
        alu_reply(16'd2468, 1'b0);
        chk("mul_disp", disp_val, 2468);
        press_str("-8=");
        chk("sub_a", alu_a, 2468);
        chk("sub_b", alu_b, 8);
        chk("sub_op", alu_op, 1);
        alu_reply(16'd2460, 1'b0);
        chk("sub_disp", disp_val, 2460);

        // Operator replacement only before any B digit
        press_str("C9+*=");
        chk("repl_op", alu_op, 2);
        chk("repl_a", alu_a, 9);
        chk("repl_b_empty", alu_b, 0);
        alu_reply(16'd0, 1'b0);
        press_str("C9+4*");
        chk("norepl_disp", disp_val, 4);
        press("=");
        chk("norepl_op", alu_op, 0);
        chk("norepl_b", alu_b, 4);
        alu_reply(16'd13, 1'b0);
        chk("norepl_res", disp_val, 13);

        // Error path
        press_str("C8/0=");
        chk("div_op", alu_op, 3);
        chk("div_disp", disp_val, 8);
        alu_reply(16'hBEEF, 1'b1);
        chk("err_flag", disp_err, 1);
        chk("err_busy", busy, 0);
        chk("err_disp_hold", disp_val, 8);
        press("7");
        press("=");
        chk("err_ignore_flag", disp_err, 1);
        chk("err_ignore_disp", disp_val, 8);
        press("C");
        chk("err_clr_flag", disp_err, 0);
        chk("err_clr_disp", disp_val, 0);

        // Back-to-back key events
        @(negedge clk);
        set_key("7");
        @(negedge clk);
        set_key("8");
        @(negedge clk);
        key_ev = 1'b0;
        chk("b2b_disp", disp_val, 78);

        // Malformed codes ignored
        press("C");
        press("3");
        @(negedge clk);
        key_ev  = 1'b1;
        key_row = 4'b0011;
        key_col = 4'b1011;
        @(negedge clk);
        key_row = 4'b1011;
        key_col = 4'b1111;
        @(negedge clk);
        key_ev  = 1'b0;
        key_row = 4'hF;
        key_col = 4'hF;
        chk("bad_code_disp", disp_val, 3);

        // Keys during EXEC ignored, including C
        press_str("+1=");
        press("4");
        chk("exec_key_a", alu_a, 3);
        chk("exec_key_b", alu_b, 1);
        press("C");
        chk("exec_clr_busy", busy, 1);
        chk("exec_clr_a", alu_a, 3);

        // Asynchronous reset mid-EXEC, then a stale done
        #2 reset = 1'b0;
        #1;
        chk("async_req", alu_req, 0);
        chk("async_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        alu_reply(16'd99, 1'b0);
        chk("late_done_req", alu_req, 0);
        chk("late_done_disp", disp_val, 0);
        chk("late_done_busy", busy, 0);
        press("6");
        chk("post_rst_key", disp_val, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
